// File: rtl/mcp_adc_responder_pkg.sv
// rtl/mcp_adc_responder_pkg.sv - shared types and command field layout for the MCP3008-style responder
package mcp_adc_pkg;

    localparam int CMD_BITS = 4;
    localparam int SGL_IDX  = 3;
    localparam int D2_IDX   = 2;
    localparam int D0_IDX   = 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CMD        = 3'd2,
        SAMPLE     = 3'd3,
        DATA       = 3'd4,
        TAIL       = 3'd5,
        DONE       = 3'd6
    } state_e;

endpackage

// File: rtl/mcp_adc_responder_if.sv
// rtl/mcp_adc_responder_if.sv - SPI pin bundle between the ADC initiator and the responder
interface mcp_adc_responder_if;
    logic cs;
    logic sclk;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output cs, output sclk, output din, input dout, input dout_oe);
    modport slave  (input cs, input sclk, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp_adc_responder_sync.sv
// rtl/mcp_adc_responder_sync.sv - pin synchronizer for cs/sclk/din with sclk edge strobes
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic din,
    output logic cs_s,
    output logic din_s,
    output logic rise_e,
    output logic fall_e
);

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] din_q;
    logic                   sclk_d;

    // cs resets deasserted so a held-low pin looks like a fresh frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= '1;
            sclk_q <= '0;
            din_q  <= '0;
            sclk_d <= 1'b0;
        end else begin
            cs_q[0]   <= cs;
            sclk_q[0] <= sclk;
            din_q[0]  <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_q[i]   <= cs_q[i-1];
                sclk_q[i] <= sclk_q[i-1];
                din_q[i]  <= din_q[i-1];
            end
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    // Edges compare two flops, so they stay glitch-free and keep pin-to-dout at SYNC_STAGES+1
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign din_s  = din_q[SYNC_STAGES-1];
    assign rise_e = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign fall_e = ~sclk_q[SYNC_STAGES-1] & sclk_d;

endmodule

// File: rtl/mcp_adc_responder.sv
// rtl/mcp_adc_responder.sv - MCP3008-style SPI ADC responder: command decode, sample request, result shift-out
module mcp_adc_responder
    import mcp_adc_pkg::*;
#(
    parameter int RES_BITS    = 10,
    parameter int CH_BITS     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_TAIL    = 1
) (
    input  logic                clk,
    input  logic                rst,
    mcp_adc_responder_if.slave  spi,
    output logic [CH_BITS-1:0]  conv_ch,
    output logic                conv_sgl,
    output logic                conv_strobe,
    input  logic [RES_BITS-1:0] sample_data,
    output logic                frame_done,
    output logic                frame_err
);

    localparam int CNT_W = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;

    logic                cs_s;
    logic                din_s;
    logic                rise_e;
    logic                fall_e;
    state_e              state;
    logic [CMD_BITS-2:0] cmd_q;
    logic [CMD_BITS-1:0] cmd_next;
    logic [CNT_W-1:0]    cnt;
    logic [RES_BITS-1:0] res_q;
    logic                dout_q;
    logic                oe_q;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .cs     (spi.cs),
        .sclk   (spi.sclk),
        .din    (spi.din),
        .cs_s   (cs_s),
        .din_s  (din_s),
        .rise_e (rise_e),
        .fall_e (fall_e)
    );

    // The last command bit is consumed straight from din_s, so only the first three are stored
    assign cmd_next    = {cmd_q, din_s};
    assign spi.dout    = dout_q;
    assign spi.dout_oe = oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            cnt         <= '0;
            res_q       <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            conv_ch     <= '0;
            conv_sgl    <= 1'b0;
            conv_strobe <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            conv_strobe <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            if (conv_strobe) begin
                res_q <= sample_data;
            end
            if (cs_s) begin
                state     <= IDLE;
                oe_q      <= 1'b0;
                dout_q    <= 1'b0;
                frame_err <= (state == CMD) || (state == SAMPLE) || (state == DATA);
            end else begin
                case (state)
                    IDLE: state <= WAIT_START;
                    WAIT_START: begin
                        if (rise_e && din_s) begin
                            state <= CMD;
                            cnt   <= '0;
                        end
                    end
                    CMD: begin
                        if (rise_e) begin
                            cmd_q <= cmd_next[CMD_BITS-2:0];
                            if (cnt == CNT_W'(CMD_BITS-1)) begin
                                conv_sgl    <= cmd_next[SGL_IDX];
                                conv_ch     <= CH_BITS'(cmd_next[D2_IDX:D0_IDX]);
                                conv_strobe <= 1'b1;
                                state       <= SAMPLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (fall_e) begin
                            oe_q   <= 1'b1;
                            dout_q <= 1'b0;
                            cnt    <= CNT_W'(RES_BITS-1);
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall_e) begin
                            dout_q <= res_q[cnt];
                            if (cnt == '0) begin
                                frame_done <= 1'b1;
                                cnt        <= CNT_W'(1);
                                state      <= (LSB_TAIL != 0) ? TAIL : DONE;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    TAIL: begin
                        if (fall_e) begin
                            dout_q <= res_q[cnt];
                            if (cnt == CNT_W'(RES_BITS-1)) begin
                                state <= DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (fall_e) begin
                            dout_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp_adc_responder.sv
// tb/tb_mcp_adc_responder.sv - self-checking bench for mcp_adc_responder with and without the LSB tail
module tb_mcp_adc_responder;

    localparam int RB = 10;
    localparam int SS = 2;
    localparam int H  = 8;

    logic          clk;
    logic          rst;
    logic [RB-1:0] sample_data;
    logic [2:0]    ch0, ch1;
    logic          sgl0, sgl1, strobe0, strobe1, done0, done1, err0, err1;

    mcp_adc_responder_if spi0 ();
    mcp_adc_responder_if spi1 ();

    assign spi1.cs   = spi0.cs;
    assign spi1.sclk = spi0.sclk;
    assign spi1.din  = spi0.din;

    mcp_adc_responder #(.RES_BITS(RB), .CH_BITS(3), .SYNC_STAGES(SS), .LSB_TAIL(1)) dut0 (
        .clk(clk), .rst(rst), .spi(spi0), .conv_ch(ch0), .conv_sgl(sgl0), .conv_strobe(strobe0),
        .sample_data(sample_data), .frame_done(done0), .frame_err(err0)
    );

    mcp_adc_responder #(.RES_BITS(RB), .CH_BITS(3), .SYNC_STAGES(SS), .LSB_TAIL(0)) dut1 (
        .clk(clk), .rst(rst), .spi(spi1), .conv_ch(ch1), .conv_sgl(sgl1), .conv_strobe(strobe1),
        .sample_data(sample_data), .frame_done(done1), .frame_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0, n_done = 0, n_err = 0, n_oe = 0, n_done1 = 0, n_oe1 = 0;
    int last_ch = 0, last_sgl = 0;

    always @(negedge clk) begin
        if (strobe0) begin
            n_strobe++;
            last_ch  = int'(ch0);
            last_sgl = int'(sgl0);
        end
        if (done0) n_done++;
        if (err0) n_err++;
        if (done1) n_done1++;
        if (spi0.dout_oe) n_oe++;
        if (spi1.dout_oe) n_oe1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected {oe, dout} after falling edge f (counted from 0 within the frame)
    function automatic logic [1:0] exp_out(input bit tail, input int lead, input logic [RB-1:0] d, input int f);
        int k;
        k = f - (lead + 4);
        if (k < 0) return 2'b00;
        if (k == 0) return 2'b10;
        if (k <= RB) return {1'b1, d[RB-k]};
        if (k <= 2*RB-1) return {1'b1, tail ? d[k-RB] : 1'b0};
        return 2'b10;
    endfunction

    task automatic check_fall(input int lead, input logic [RB-1:0] d, input int f);
        logic [1:0] e0, e1;
        e0 = exp_out(1'b1, lead, d, f);
        e1 = exp_out(1'b0, lead, d, f);
        check($sformatf("oe tail f%0d", f), int'(spi0.dout_oe), int'(e0[1]));
        check($sformatf("dout tail f%0d", f), int'(spi0.dout), int'(e0[0]));
        check($sformatf("oe notail f%0d", f), int'(spi1.dout_oe), int'(e1[1]));
        check($sformatf("dout notail f%0d", f), int'(spi1.dout), int'(e1[0]));
    endtask

    task automatic run_frame(input int lead, input bit sgl, input int ch, input logic [RB-1:0] d,
                             input int nsclk, input bit end_rst,
                             input int e_strobe, input int e_done, input int e_err);
        int s0, dn0, er0, dn1;
        logic [3:0] c;
        s0  = n_strobe;
        dn0 = n_done;
        er0 = n_err;
        dn1 = n_done1;
        c = {sgl, ch[2:0]};
        sample_data = d;
        spi0.cs  = 1'b0;
        spi0.din = 1'b0;
        repeat (H) tick();
        for (int i = 0; i < nsclk; i++) begin
            if (i < lead) spi0.din = 1'b0;
            else if (i == lead) spi0.din = 1'b1;
            else if (i <= lead + 4) spi0.din = c[3-(i-lead-1)];
            else spi0.din = 1'($urandom);
            repeat (H) tick();
            if (i > 0) check_fall(lead, d, i - 1);
            spi0.sclk = 1'b1;
            repeat (H) tick();
            if (i == lead + 4) sample_data = ~d;
            spi0.sclk = 1'b0;
        end
        repeat (H) tick();
        if (nsclk > 0) check_fall(lead, d, nsclk - 1);
        if (end_rst) begin
            rst = 1'b1;
            tick();
            check("rst dout", int'(spi0.dout), 0);
            check("rst oe", int'(spi0.dout_oe), 0);
            check("rst ch", int'(ch0), 0);
            check("rst sgl", int'(sgl0), 0);
            rst = 1'b0;
        end
        spi0.cs = 1'b1;
        repeat (SS + 2) tick();
        check("oe after cs", int'(spi0.dout_oe), 0);
        check("dout after cs", int'(spi0.dout), 0);
        check("oe1 after cs", int'(spi1.dout_oe), 0);
        repeat (H) tick();
        check("strobe count", n_strobe - s0, e_strobe);
        check("done count", n_done - dn0, e_done);
        check("done1 count", n_done1 - dn1, e_done);
        check("err count", n_err - er0, e_err);
        if (e_strobe > 0) begin
            check("conv_ch", last_ch, ch);
            check("conv_sgl", last_sgl, int'(sgl));
        end
    endtask

    typedef struct {
        int            lead;
        bit            sgl;
        int            ch;
        logic [RB-1:0] data;
        int            nsclk;
        int            e_strobe;
        int            e_done;
        int            e_err;
    } frame_t;

    initial begin
        frame_t vec[8];
        int o0, o1, s0, dn0, er0;
        vec[0] = '{7, 1'b1, 5, 10'h2A5, 40, 1, 1, 0};
        vec[1] = '{7, 1'b1, 5, 10'h2A5, 24, 1, 1, 0};
        vec[2] = '{2, 1'b1, 2, 10'h155, 11, 1, 0, 1};
        vec[3] = '{0, 1'b0, 0, 10'h3FF, 20, 1, 1, 0};
        vec[4] = '{0, 1'b1, 7, 10'h000, 4, 0, 0, 1};
        vec[5] = '{3, 1'b1, 1, 10'h200, 3, 0, 0, 0};
        vec[6] = '{1, 1'b0, 6, 10'h1C3, 16, 1, 1, 0};
        vec[7] = '{1, 1'b0, 6, 10'h1C3, 15, 1, 0, 1};

        rst = 1'b1;
        spi0.cs = 1'b1;
        spi0.sclk = 1'b0;
        spi0.din = 1'b0;
        sample_data = '0;
        repeat (4) tick();
        check("reset dout", int'(spi0.dout), 0);
        check("reset oe", int'(spi0.dout_oe), 0);
        check("reset ch", int'(ch0), 0);
        check("reset sgl", int'(sgl0), 0);
        check("reset strobe", int'(strobe0), 0);
        check("reset done", int'(done0), 0);
        check("reset err", int'(err0), 0);
        rst = 1'b0;
        repeat (H) tick();

        for (int v = 0; v < 8; v++) begin
            run_frame(vec[v].lead, vec[v].sgl, vec[v].ch, vec[v].data, vec[v].nsclk, 1'b0,
                      vec[v].e_strobe, vec[v].e_done, vec[v].e_err);
        end

        run_frame(2, 1'b1, 3, 10'h2F0, 10, 1'b1, 1, 0, 0);
        run_frame(5, 1'b1, 4, 10'h001, 30, 1'b0, 1, 1, 0);

        for (int r = 0; r < 8; r++) begin
            int lead, ns, es, ed, ee;
            lead = int'($urandom_range(0, 6));
            ns   = int'($urandom_range(0, 35));
            es = (ns >= lead + 5) ? 1 : 0;
            ed = (ns >= lead + 15) ? 1 : 0;
            ee = (ns >= lead + 1 && ns <= lead + 14) ? 1 : 0;
            run_frame(lead, 1'($urandom), int'($urandom_range(0, 7)), 10'($urandom), ns, 1'b0, es, ed, ee);
        end

        o0 = n_oe; o1 = n_oe1; s0 = n_strobe; dn0 = n_done; er0 = n_err;
        spi0.cs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spi0.din = 1'($urandom);
            spi0.sclk = 1'b1;
            repeat (4) tick();
            spi0.sclk = 1'b0;
            repeat (4) tick();
        end
        check("idle oe cycles", n_oe - o0, 0);
        check("idle oe1 cycles", n_oe1 - o1, 0);
        check("idle strobes", n_strobe - s0, 0);
        check("idle done", n_done - dn0, 0);
        check("idle err", n_err - er0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp_adc_responder.md
Name: mcp_adc_responder

Overview:
- Synthesizable SPI responder that emulates the MCP3008-style 10-bit ADC; it is the device end of the existing ADC SPI initiator path (cs, sclk, din, doutb).
- Lets the temperature/LED/LCD chain run on a board without the ADC fitted, or in simulation with a second FPGA image acting as the ADC.
- Decodes the start/SGL/channel command, requests a sample from a local value source and shifts the result back MSB first.

Parameters:
- RES_BITS, 10, result width returned per conversion.
- CH_BITS, 3, channel field width (D2..D0).
- SYNC_STAGES, 2, flip-flop stages on the cs/sclk/din inputs.
- LSB_TAIL, 1, if 1, extra clocks after B0 return B1..B(RES_BITS-1) LSB first; if 0, the block drives 0.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select from the initiator, active low.
- sclk  in  1  SPI clock from the initiator; mode 0,0.
- din  in  1  command bits from the initiator.
- dout  out  1  result bit; the top level drives doutb = dout_oe ? dout : 1'bz.
- dout_oe  out  1  output enable.
- conv_ch  out  CH_BITS  channel decoded from the command.
- conv_sgl  out  1  SGL/DIFF bit decoded from the command.
- conv_strobe  out  1  one-cycle pulse; the external source must present sample_data in the same cycle.
- sample_data  in  RES_BITS  value to return; latched on conv_strobe.
- frame_done  out  1  one-cycle pulse when a frame ends normally.
- frame_err  out  1  one-cycle pulse when cs rises before B0 is shifted.

Behaviour:
- Input conditioning:
  - cs, sclk and din each pass through SYNC_STAGES flip-flops.
  - Edges are detected on synchronized sclk against one more register.
  - rise_e and fall_e are each one clk cycle long.
  - Latency from a pin edge to the dout update is SYNC_STAGES+1 clk cycles.
- Reset values:
  - dout=0, dout_oe=0, conv_ch=0, conv_sgl=0.
  - conv_strobe, frame_done and frame_err are 0.
  - State is IDLE; the shift register and bit counter are 0.
- cs high (synchronized), in any state: go to IDLE next cycle with dout_oe=0 and dout=0.
  - If the state was CMD, SAMPLE or DATA, also pulse frame_err.
  - cs high has priority over a simultaneous sclk edge.
- IDLE: on cs low, go to WAIT_START.
- WAIT_START:
  - On rise_e with din=1 (start bit), go to CMD and set cnt=0.
  - On rise_e with din=0, stay in WAIT_START (leading zeros allowed).
- CMD:
  - On each rise_e, shift din into cmd[3:0], MSB first: SGL, D2, D1, D0.
  - After the 4th bit, in the same cycle:
    - conv_sgl <= cmd bit 3; conv_ch <= D2..D0.
    - Pulse conv_strobe in the following cycle and latch sample_data into res_q in that same following cycle.
  - Then go to SAMPLE.
- SAMPLE: on the first fall_e, set dout_oe=1 and dout=0 (null bit), set cnt=RES_BITS-1, go to DATA.
- DATA:
  - On each fall_e, dout <= res_q[cnt].
  - When cnt reaches 0 (B0 driven), go to TAIL if LSB_TAIL=1, else DONE; pulse frame_done at that point.
  - Otherwise decrement cnt.
- TAIL:
  - On each fall_e, cnt increments from 1 and dout <= res_q[cnt].
  - After res_q[RES_BITS-1] is driven, go to DONE.
- DONE: on fall_e, dout=0; dout_oe stays 1 until cs rises.
- Rising edges after the command are ignored; din is don't-care.
- A frame with cs held low for fewer than 5 rising edges produces no conv_strobe.
- Reset asserted mid-frame: the block returns to reset values in the next cycle; no frame_err.
- A new frame requires cs high for at least SYNC_STAGES+1 clk cycles.

Decomposition:
- Package mcp_adc_pkg holds:
  - the state enum: IDLE, WAIT_START, CMD, SAMPLE, DATA, TAIL, DONE;
  - the command field indices (SGL=3, D2..D0=2..0);
  - CMD_BITS=4.
- Sub-module spi_pin_sync: parameterised SYNC_STAGES synchronizer for cs/sclk/din, with registered rise_e/fall_e outputs for sclk. The FSM and shifter stay in mcp_adc_responder.

Test Plan:
- Single-ended channel 5, sample_data=10'h2A5, 24 sclk frame with 7 leading zeros:
  - conv_ch=5, conv_sgl=1, one conv_strobe.
  - dout sequence after D0: 0, 1,0,1,0,1,0,0,1,0,1.
  - Followed by the LSB tail 0,1,0,0,1,0,1,0,1 (bits B1..B9); frame_done pulses once.
- LSB_TAIL=0 with the same frame: every bit after B0 is 0, and dout_oe=1 until cs rises.
- cs rises after 4 data bits of channel 2: one frame_err pulse, dout_oe=0 within SYNC_STAGES+2 cycles, no frame_done.
- Differential channel 0, sample_data=10'h3FF: conv_sgl=0, ten 1s after the null bit.
- rst pulsed during DATA:
  - all outputs go to reset values the next cycle.
  - The next full frame with sample_data=10'h001 returns nine 0s then a 1.
- cs high and sclk toggling: dout_oe stays 0, with no conv_strobe and no frame pulses.
